// File: rtl/adc_level_meter.sv
// adc_level_meter: windowed peak-magnitude meter with decaying held level and clip flag
module adc_level_meter #(
  parameter int WINDOW = 519,
  parameter int DECAY = 1
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic [5:0]  level,
  output logic        level_valid,
  output logic        clip
);
  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam logic [5:0] DEC = 6'(DECAY);
  logic [CW-1:0] count;
  logic [10:0] peak, mag, peak_n;
  logic [5:0] win, dec;
  logic acc, rail, last;
  // below midscale the magnitude 2047-sample is just the inverted low bits
  always_comb begin
    mag = sample[11] ? sample[10:0] : ~sample[10:0];
    peak_n = mag > peak ? mag : peak;
    win = peak_n[10:5];
    rail = sample == 12'd0 || &sample;
    last = sample_valid && count == LAST;
    dec = level > DEC ? level - DEC : 6'd0;
  end
  // max(win, level-DECAY) also covers win >= level, since then win >= level-DECAY
  always_ff @(posedge dclk or posedge rst)
    if (rst) begin
      count <= '0;
      peak <= '0;
      acc <= 1'b0;
      level <= '0;
      level_valid <= 1'b0;
      clip <= 1'b0;
    end else begin
      level_valid <= last;
      if (sample_valid) begin
        count <= last ? '0 : count + 1'b1;
        peak <= last ? '0 : peak_n;
        acc <= ~last & (acc | rail);
      end
      if (last) begin
        level <= win > dec ? win : dec;
        clip <= acc | rail;
      end
    end
endmodule

// File: doc/adc_level_meter.md
ADC_LEVEL_METER -- requirements
Module: adc_level_meter

Interface
REQ-001 Parameter WINDOW, default 519, accepted samples per measurement window (44100 Hz / 519 = 85 Hz update); legal range 2..4095.
REQ-002 Parameter DECAY, default 1, amount the held level falls per window when the signal drops; legal range 0..63.
REQ-003 dclk  input  1  system clock, 44100 Hz sample-rate domain; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample  input  12  ADC sample, offset binary, midscale 2048 = zero signal.
REQ-006 sample_valid  input  1  qualifies sample for one dclk cycle; sample accepted when high at a rising edge.
REQ-007 level  output  6  held magnitude level for the bar-graph LED driver, registered.
REQ-008 level_valid  output  1  one-cycle pulse marking a new level value.
REQ-009 clip  output  1  registered; high when the last completed window contained a sample at a rail (0 or 4095).

Function
REQ-010 Magnitude SHALL be computed combinationally per sample: sample >= 2048 -> mag = sample - 2048; sample < 2048 -> mag = 2047 - sample; mag is 11 bits, range 0..2047, never overflows.
REQ-011 On each accepted sample the window peak register SHALL update to max(peak, mag).
REQ-012 A window counter SHALL count accepted samples 0..WINDOW-1; cycles with sample_valid low change neither the counter nor the peak.
REQ-013 On the edge accepting the sample at count WINDOW-1 (the window-end edge): win = max(peak, mag)[10:5]; counter -> 0; peak -> 0; clip-accumulate flag -> 0.
REQ-014 On the window-end edge the held level SHALL update to win when win >= level, else to max(win, level - DECAY), where level - DECAY saturates at 0.
REQ-015 level_valid SHALL be high for exactly the one cycle after the window-end edge, low otherwise, whether or not level changed.
REQ-016 Latency: level, clip and level_valid reflect the final window sample in the cycle immediately after it is accepted.
REQ-017 A clip-accumulate flag SHALL set on any accepted sample equal to 0 or 4095; on the window-end edge clip loads (flag OR current-sample-is-rail).
REQ-018 level and clip SHALL hold their values between window-end edges.
REQ-019 Back-to-back sample_valid (every cycle) SHALL be supported with no lost samples; windows abut with no gap sample.
REQ-020 The window-end sample SHALL belong to the closing window only; the next window starts with peak 0 at the following accepted sample.
REQ-021 With DECAY = 0 the held level SHALL never decrease except by reset.

Reset
REQ-022 While rst is high: level = 0, level_valid = 0, clip = 0, counter = 0, peak = 0, clip-accumulate flag = 0.
REQ-023 rst asserted mid-window SHALL discard the partial window; the first accepted sample after release is count 0.
REQ-024 Release of rst SHALL take effect at the next rising edge of dclk; no output pulses on release.

Verification
REQ-025 WINDOW=4, DECAY=1, samples 2048,2100,1900,2300 back-to-back -> one cycle after 4th accept: level=7 (mag 252 -> 252>>5), level_valid pulses 1 cycle, clip=0.
REQ-026 WINDOW=4, DECAY=1, prior level=7, next window all 2048 -> level=6; three more silent windows -> 5, 4, 3; level_valid each window.
REQ-027 WINDOW=4, samples 0,2048,2048,2048 (mag 2047) -> level=63, clip=1; next window 2048 x4 -> level=62, clip=0.
REQ-028 WINDOW=4, sample_valid asserted every third cycle with 4095 in 2nd sample -> level=63 only after 4th valid sample; gaps do not advance counter.
REQ-029 WINDOW=4, rst pulsed after 2 accepted samples of 4095 -> level=0, clip=0 immediately; then 4 samples of 2048 -> level=0, level_valid after 4th, clip=0.
REQ-030 Default WINDOW=519, continuous valid, sinewave amplitude 1000 -> level_valid period exactly 519 cycles, level=31 after first window.
